ctrl_id: RTL and testbench
==========================

// Module: ctrl_id
// PURPOSE
//  Decode-stage read-side control: the counterpart of the write-back control. Decodes
//  the ID-stage Thumb instruction (ADD imm3, SUB SP, MOV imm, MOV reg, LDR imm) and
//  produces register-file read addresses and enables. Keeps a per-register scoreboard
//  of in-flight writes, counted up at issue and down by the WB write port. Stalls ID on
//  RAW or scoreboard saturation, and hands IR plus a valid bit to EX.
// PARAMETERS
//  NUM_REGS  16  architectural registers tracked (r0..r15, SP = 13)
//  ADDR_W    4   register address width
//  CNT_W     2   per-register in-flight counter width; max = 2**CNT_W-1
// PORTS
//  clk                 in   1       clock, rising edge
//  rst                 in   1       reset, asynchronous, active-low
//  i_ir_id             in   16      instruction in ID
//  i_ir_valid          in   1       i_ir_id holds a real instruction
//  i_stall             in   1       downstream stall: hold EX outputs, no issue
//  i_flush             in   1       kill ID instruction (bubble to EX)
//  i_wb_addr_rd        in   ADDR_W  WB destination (from write-back control)
//  i_wb_rd_en          in   1       WB write strobe, one per retiring writer
//  o_addr_rn_r         out  ADDR_W  registered read address, port A
//  o_addr_rm_r         out  ADDR_W  registered read address, port B
//  o_registers_rn_en   out  1       port A read enable
//  o_registers_rm_en   out  1       port B read enable
//  o_ir_ex             out  16      instruction forwarded to EX
//  o_valid_ex          out  1       o_ir_ex is valid
//  o_hazard_stall      out  1       combinational: ID must hold this cycle
//  o_sb_err            out  1       sticky: WB strobe for a register with count 0
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; all counters 0; o_sb_err 0.
//  Decode (combinational, shared package functions, identical to the WB decode):
//   ADD imm3 0001110??: src Rn=ir[5:3], dst ir[2:0]
//   SUB SP   101100001: src 13, dst 13
//   MOV imm  00100????: no src, dst ir[10:8]
//   MOV reg  01000110?: src ir[6:3], dst {ir[7],ir[2:0]}
//   LDR imm  01101????: src ir[5:3], dst ir[2:0]
//   other:   no src, no dst; passed to EX as valid (EX traps)
//  Hazard: o_hazard_stall = i_ir_valid & !i_flush & (cnt[src]!=0 for any used src
//   | dst used & cnt[dst]==max). Uses registered counts only, so there is no
//   same-cycle WB bypass.
//  Issue = i_ir_valid & !o_hazard_stall & !i_stall & !i_flush.
//  EX register update, 1-cycle latency:
//   i_stall: hold all o_* registered outputs (read enables forced to 0, as in WB).
//   else issue: o_ir_ex<=i_ir_id, o_valid_ex<=1, addrs/enables from decode
//    (unused port: address 0, enable 0).
//   else (hazard, flush or !valid): o_valid_ex<=0, enables<=0, addresses hold.
//  Scoreboard: on issue with dst, cnt[dst]+1. On i_wb_rd_en, cnt[i_wb_addr_rd]-1.
//   Both on the same register in the same cycle: net unchanged. Decrement at 0 leaves
//   0 and sets o_sb_err, which clears only on reset. Increment never exceeds max,
//   because the hazard prevents it.
//  Flush never touches counters; in-flight writers still retire through WB.
//  Reset mid-stall or mid-hazard: immediate clear; next instruction after reset
//   issues at once.
// STRUCTURE
//  Package ctrl_pkg: opcode pattern constants, SP_ADDR=13, functions dec_src_a,
//   dec_src_b, dec_dst returning {used,addr}. The WB control is refactored to use
//   the same dec_dst.
//  Sub-module ctrl_scoreboard: counter array, inc/dec ports, busy[NUM_REGS],
//   full[NUM_REGS], err.
// TESTING
//  1 MOV r1,#5 (0x2105) then ADD r2,r1,#1 (0x1C4A) -> stall until WB r1 strobe;
//    ADD issues the cycle after, o_addr_rn_r=1.
//  2 SUB SP (0xB081) -> o_addr_rn_r=13, rn_en=1; cnt[13]=1; WB 13 -> cnt[13]=0.
//  3 Issue MOV r3 and WB strobe r3 in the same cycle with cnt[3]=1 -> cnt[3] stays 1.
//  4 Issue MOV r0 three times, no WB -> 4th stalls (cnt=3); one WB r0 -> issues next cycle.
//  5 i_stall=1 for 3 cycles with ADD in EX -> o_ir_ex/o_valid_ex held, no count
//    change; rst=0 pulse mid-stall -> all outputs 0 immediately.
//  6 WB strobe r7 with cnt[7]=0 -> o_sb_err=1 next cycle, stays 1 until reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared Thumb decode helpers for the ID and WB control blocks
package ctrl_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int CNT_W    = 2;

    localparam logic [ADDR_W-1:0] SP_ADDR = 4'd13;

    localparam logic [15:0] ADD_IMM3_MASK = 16'hFE00;
    localparam logic [15:0] ADD_IMM3_PAT  = 16'h1C00;
    localparam logic [15:0] SUB_SP_MASK   = 16'hFF80;
    localparam logic [15:0] SUB_SP_PAT    = 16'hB080;
    localparam logic [15:0] MOV_IMM_MASK  = 16'hF800;
    localparam logic [15:0] MOV_IMM_PAT   = 16'h2000;
    localparam logic [15:0] MOV_REG_MASK  = 16'hFF00;
    localparam logic [15:0] MOV_REG_PAT   = 16'h4600;
    localparam logic [15:0] LDR_IMM_MASK  = 16'hF800;
    localparam logic [15:0] LDR_IMM_PAT   = 16'h6800;

    typedef enum logic [2:0] {
        OP_ADD_IMM3,
        OP_SUB_SP,
        OP_MOV_IMM,
        OP_MOV_REG,
        OP_LDR_IMM,
        OP_OTHER
    } op_t;

    typedef struct packed {
        logic              used;
        logic [ADDR_W-1:0] addr;
    } reg_ref_t;

    function automatic op_t dec_op(input logic [15:0] ir);
        if ((ir & ADD_IMM3_MASK) == ADD_IMM3_PAT) return OP_ADD_IMM3;
        if ((ir & SUB_SP_MASK)   == SUB_SP_PAT)   return OP_SUB_SP;
        if ((ir & MOV_IMM_MASK)  == MOV_IMM_PAT)  return OP_MOV_IMM;
        if ((ir & MOV_REG_MASK)  == MOV_REG_PAT)  return OP_MOV_REG;
        if ((ir & LDR_IMM_MASK)  == LDR_IMM_PAT)  return OP_LDR_IMM;
        return OP_OTHER;
    endfunction

    // Port A carries Rn-style sources; MOV reg reads its Rm through port B.
    function automatic reg_ref_t dec_src_a(input logic [15:0] ir);
        reg_ref_t r;
        r = '0;
        case (dec_op(ir))
            OP_ADD_IMM3, OP_LDR_IMM: r = '{used: 1'b1, addr: {1'b0, ir[5:3]}};
            OP_SUB_SP:               r = '{used: 1'b1, addr: SP_ADDR};
            default:                 r = '0;
        endcase
        return r;
    endfunction

    function automatic reg_ref_t dec_src_b(input logic [15:0] ir);
        reg_ref_t r;
        r = '0;
        if (dec_op(ir) == OP_MOV_REG) begin
            r = '{used: 1'b1, addr: ir[6:3]};
        end
        return r;
    endfunction

    function automatic reg_ref_t dec_dst(input logic [15:0] ir);
        reg_ref_t r;
        r = '0;
        case (dec_op(ir))
            OP_ADD_IMM3, OP_LDR_IMM: r = '{used: 1'b1, addr: {1'b0, ir[2:0]}};
            OP_SUB_SP:               r = '{used: 1'b1, addr: SP_ADDR};
            OP_MOV_IMM:              r = '{used: 1'b1, addr: {1'b0, ir[10:8]}};
            OP_MOV_REG:              r = '{used: 1'b1, addr: {ir[7], ir[2:0]}};
            default:                 r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ctrl_scoreboard.sv
// rtl/ctrl_scoreboard.sv - per-register in-flight write counters with busy/full flags
module ctrl_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic [ADDR_W-1:0]   inc_addr,
    input  logic                dec,
    input  logic [ADDR_W-1:0]   dec_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic [NUM_REGS-1:0] full,
    output logic                err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0] zero;
    logic                same_reg;

    assign same_reg = inc && dec && (inc_addr == dec_addr);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        logic             inc_hit;
        logic             dec_hit;

        assign inc_hit = inc && (inc_addr == ADDR_W'(g));
        assign dec_hit = dec && (dec_addr == ADDR_W'(g));

        // A matched inc/dec pair cancels; the saturation guards are belt and braces.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
            end else if (inc_hit && !dec_hit) begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            end else if (dec_hit && !inc_hit) begin
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
        end

        assign busy[g] = (cnt != '0);
        assign full[g] = (cnt == CNT_MAX);
        assign zero[g] = (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (dec && !same_reg && zero[dec_addr]) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_id.sv
// rtl/ctrl_id.sv - ID-stage read control: decode, RAW/scoreboard stall, EX handoff
module ctrl_id
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       i_ir_id,
    input  logic              i_ir_valid,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_wb_addr_rd,
    input  logic              i_wb_rd_en,
    output logic [ADDR_W-1:0] o_addr_rn_r,
    output logic [ADDR_W-1:0] o_addr_rm_r,
    output logic              o_registers_rn_en,
    output logic              o_registers_rm_en,
    output logic [15:0]       o_ir_ex,
    output logic              o_valid_ex,
    output logic              o_hazard_stall,
    output logic              o_sb_err
);

    reg_ref_t            src_a;
    reg_ref_t            src_b;
    reg_ref_t            dst;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] full;
    logic                raw_hit;
    logic                full_hit;
    logic                issue;

    assign src_a = dec_src_a(i_ir_id);
    assign src_b = dec_src_b(i_ir_id);
    assign dst   = dec_dst(i_ir_id);

    // Registered counts only: a WB strobe this cycle does not release a stall until next cycle.
    assign raw_hit  = (src_a.used && busy[src_a.addr]) || (src_b.used && busy[src_b.addr]);
    assign full_hit = dst.used && full[dst.addr];

    assign o_hazard_stall = i_ir_valid && !i_flush && (raw_hit || full_hit);
    assign issue          = i_ir_valid && !o_hazard_stall && !i_stall && !i_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ir_ex           <= '0;
            o_valid_ex        <= 1'b0;
            o_addr_rn_r       <= '0;
            o_addr_rm_r       <= '0;
            o_registers_rn_en <= 1'b0;
            o_registers_rm_en <= 1'b0;
        end else if (i_stall) begin
            o_registers_rn_en <= 1'b0;
            o_registers_rm_en <= 1'b0;
        end else if (issue) begin
            o_ir_ex           <= i_ir_id;
            o_valid_ex        <= 1'b1;
            o_addr_rn_r       <= src_a.used ? src_a.addr : '0;
            o_addr_rm_r       <= src_b.used ? src_b.addr : '0;
            o_registers_rn_en <= src_a.used;
            o_registers_rm_en <= src_b.used;
        end else begin
            o_valid_ex        <= 1'b0;
            o_registers_rn_en <= 1'b0;
            o_registers_rm_en <= 1'b0;
        end
    end

    ctrl_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .inc      (issue && dst.used),
        .inc_addr (dst.addr),
        .dec      (i_wb_rd_en),
        .dec_addr (i_wb_addr_rd),
        .busy     (busy),
        .full     (full),
        .err      (o_sb_err)
    );

endmodule

// File: tb/tb_ctrl_id.sv
// tb/tb_ctrl_id.sv - self-checking bench for ctrl_id against a behavioural model
module tb_ctrl_id;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ir_id = '0;
    logic        ir_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic        wb_en = 1'b0;

    logic [3:0]  o_addr_rn_r;
    logic [3:0]  o_addr_rm_r;
    logic        o_registers_rn_en;
    logic        o_registers_rm_en;
    logic [15:0] o_ir_ex;
    logic        o_valid_ex;
    logic        o_hazard_stall;
    logic        o_sb_err;

    int checks = 0;
    int errors = 0;

    int          m_cnt [16];
    bit          m_err;
    logic [15:0] m_ir;
    bit          m_valid;
    logic [3:0]  m_rn, m_rm;
    bit          m_rn_en, m_rm_en;

    ctrl_id dut (
        .clk               (clk),
        .rst               (rst),
        .i_ir_id           (ir_id),
        .i_ir_valid        (ir_valid),
        .i_stall           (stall),
        .i_flush           (flush),
        .i_wb_addr_rd      (wb_addr),
        .i_wb_rd_en        (wb_en),
        .o_addr_rn_r       (o_addr_rn_r),
        .o_addr_rm_r       (o_addr_rm_r),
        .o_registers_rn_en (o_registers_rn_en),
        .o_registers_rm_en (o_registers_rm_en),
        .o_ir_ex           (o_ir_ex),
        .o_valid_ex        (o_valid_ex),
        .o_hazard_stall    (o_hazard_stall),
        .o_sb_err          (o_sb_err)
    );

    always #5 clk = ~clk;

    function automatic void m_decode(input logic [15:0] ir,
                                     output bit au, output logic [3:0] aa,
                                     output bit bu, output logic [3:0] ba,
                                     output bit du, output logic [3:0] da);
        au = 0; aa = 0; bu = 0; ba = 0; du = 0; da = 0;
        casez (ir)
            16'b0001110?????????: begin au = 1; aa = {1'b0, ir[5:3]}; du = 1; da = {1'b0, ir[2:0]}; end
            16'b101100001???????: begin au = 1; aa = 4'd13; du = 1; da = 4'd13; end
            16'b00100???????????: begin du = 1; da = {1'b0, ir[10:8]}; end
            16'b01000110????????: begin bu = 1; ba = ir[6:3]; du = 1; da = {ir[7], ir[2:0]}; end
            16'b01101???????????: begin au = 1; aa = {1'b0, ir[5:3]}; du = 1; da = {1'b0, ir[2:0]}; end
            default: ;
        endcase
    endfunction

    function automatic bit m_hazard();
        bit au, bu, du;
        logic [3:0] aa, ba, da;
        m_decode(ir_id, au, aa, bu, ba, du, da);
        return ir_valid && !flush &&
               ((au && m_cnt[aa] != 0) || (bu && m_cnt[ba] != 0) || (du && m_cnt[da] == 3));
    endfunction

    task automatic m_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_err = 0; m_ir = 0; m_valid = 0; m_rn = 0; m_rm = 0; m_rn_en = 0; m_rm_en = 0;
    endtask

    // One clock: sample inputs as the DUT will, advance, update the model, settle.
    task automatic tick();
        bit au, bu, du, haz, iss;
        logic [3:0] aa, ba, da;
        m_decode(ir_id, au, aa, bu, ba, du, da);
        haz = m_hazard();
        iss = ir_valid && !haz && !stall && !flush;
        @(posedge clk);
        if (stall) begin
            m_rn_en = 0; m_rm_en = 0;
        end else if (iss) begin
            m_ir = ir_id; m_valid = 1;
            m_rn = au ? aa : 4'd0; m_rn_en = au;
            m_rm = bu ? ba : 4'd0; m_rm_en = bu;
        end else begin
            m_valid = 0; m_rn_en = 0; m_rm_en = 0;
        end
        if (!(iss && du && wb_en && wb_addr == da)) begin
            if (iss && du) m_cnt[da]++;
            if (wb_en) begin
                if (m_cnt[wb_addr] == 0) m_err = 1;
                else m_cnt[wb_addr]--;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 0; ir_valid = 0; stall = 0; flush = 0; wb_en = 0;
        m_reset();
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        ir_id = 16'h2105; ir_valid = 1;
        tick();
        ir_id = 16'h4608; #1;
        checks++; if (o_hazard_stall !== 1'b1) begin errors++; $display("FAIL reset_pre_hazard got %0b want 1", o_hazard_stall); end
        rst = 0; #1;
        m_reset();
        checks++; if (o_valid_ex !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", o_valid_ex); end
        checks++; if (o_ir_ex !== 16'h0) begin errors++; $display("FAIL reset_ir got %h want 0000", o_ir_ex); end
        checks++; if (o_addr_rn_r !== 4'd0 || o_addr_rm_r !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d/%0d want 0/0", o_addr_rn_r, o_addr_rm_r); end
        checks++; if (o_registers_rn_en !== 1'b0 || o_registers_rm_en !== 1'b0) begin errors++; $display("FAIL reset_en got %0b/%0b want 0/0", o_registers_rn_en, o_registers_rm_en); end
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_hazard got %0b want 0", o_hazard_stall); end
        checks++; if (o_sb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", o_sb_err); end
        apply_reset();
    endtask

    task automatic test_raw();
        apply_reset();
        ir_id = 16'h2105; ir_valid = 1; #1;
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("FAIL raw_mov_hazard got %0b want 0", o_hazard_stall); end
        tick();
        checks++; if (o_valid_ex !== 1'b1 || o_ir_ex !== 16'h2105) begin errors++; $display("FAIL raw_mov_issue got %0b/%h want 1/2105", o_valid_ex, o_ir_ex); end
        ir_id = 16'h1C4A;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (o_hazard_stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %0b want 1", o_hazard_stall); end
            tick();
            checks++; if (o_valid_ex !== 1'b0) begin errors++; $display("FAIL raw_bubble got %0b want 0", o_valid_ex); end
        end
        wb_addr = 4'd1; wb_en = 1; #1;
        checks++; if (o_hazard_stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass got %0b want 1", o_hazard_stall); end
        tick();
        wb_en = 0; #1;
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("FAIL raw_release got %0b want 0", o_hazard_stall); end
        tick();
        checks++; if (o_valid_ex !== 1'b1 || o_ir_ex !== 16'h1C4A) begin errors++; $display("FAIL raw_add_issue got %0b/%h want 1/1c4a", o_valid_ex, o_ir_ex); end
        checks++; if (o_addr_rn_r !== 4'd1 || o_registers_rn_en !== 1'b1 || o_registers_rm_en !== 1'b0) begin errors++; $display("FAIL raw_add_ports got rn=%0d en=%0b/%0b want 1 1/0", o_addr_rn_r, o_registers_rn_en, o_registers_rm_en); end
        ir_valid = 0;
    endtask

    task automatic test_sub_sp();
        apply_reset();
        ir_id = 16'hB081; ir_valid = 1;
        tick();
        checks++; if (o_addr_rn_r !== 4'd13 || o_registers_rn_en !== 1'b1) begin errors++; $display("FAIL sp_port got %0d/%0b want 13/1", o_addr_rn_r, o_registers_rn_en); end
        #1;
        checks++; if (o_hazard_stall !== 1'b1) begin errors++; $display("FAIL sp_busy got %0b want 1", o_hazard_stall); end
        ir_valid = 0; wb_addr = 4'd13; wb_en = 1;
        tick();
        wb_en = 0; ir_valid = 1; #1;
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("FAIL sp_cleared got %0b want 0", o_hazard_stall); end
        ir_valid = 0;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        ir_id = 16'h2300; ir_valid = 1;
        tick();
        wb_addr = 4'd3; wb_en = 1; #1;
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("FAIL same_hazard got %0b want 0", o_hazard_stall); end
        tick();
        wb_en = 0;
        checks++; if (o_valid_ex !== 1'b1) begin errors++; $display("FAIL same_issue got %0b want 1", o_valid_ex); end
        ir_id = 16'h4618; #1;
        checks++; if (o_hazard_stall !== 1'b1) begin errors++; $display("FAIL same_cnt_kept got %0b want 1", o_hazard_stall); end
        ir_valid = 0; wb_en = 1;
        tick();
        wb_en = 0; ir_valid = 1; #1;
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("FAIL same_cnt_one got %0b want 0", o_hazard_stall); end
        checks++; if (o_sb_err !== 1'b0) begin errors++; $display("FAIL same_err got %0b want 0", o_sb_err); end
        ir_valid = 0;
    endtask

    task automatic test_saturate();
        apply_reset();
        ir_id = 16'h2000; ir_valid = 1;
        repeat (3) tick();
        #1;
        checks++; if (o_hazard_stall !== 1'b1) begin errors++; $display("FAIL sat_full got %0b want 1", o_hazard_stall); end
        tick();
        checks++; if (o_valid_ex !== 1'b0) begin errors++; $display("FAIL sat_bubble got %0b want 0", o_valid_ex); end
        wb_addr = 4'd0; wb_en = 1; #1;
        checks++; if (o_hazard_stall !== 1'b1) begin errors++; $display("FAIL sat_no_bypass got %0b want 1", o_hazard_stall); end
        tick();
        wb_en = 0; #1;
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("FAIL sat_release got %0b want 0", o_hazard_stall); end
        tick();
        checks++; if (o_valid_ex !== 1'b1) begin errors++; $display("FAIL sat_issue got %0b want 1", o_valid_ex); end
        ir_valid = 0;
    endtask

    task automatic test_stall_hold();
        apply_reset();
        ir_id = 16'h1C4A; ir_valid = 1;
        tick();
        stall = 1; ir_id = 16'h2105;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_ir_ex !== 16'h1C4A || o_valid_ex !== 1'b1) begin errors++; $display("FAIL stall_hold got %h/%0b want 1c4a/1", o_ir_ex, o_valid_ex); end
            checks++; if (o_addr_rn_r !== 4'd1 || o_registers_rn_en !== 1'b0) begin errors++; $display("FAIL stall_ports got %0d/%0b want 1/0", o_addr_rn_r, o_registers_rn_en); end
        end
        ir_id = 16'h4608; #1;
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("FAIL stall_no_inc got %0b want 0", o_hazard_stall); end
        ir_id = 16'h4610; #1;
        checks++; if (o_hazard_stall !== 1'b1) begin errors++; $display("FAIL stall_r2_busy got %0b want 1", o_hazard_stall); end
        wb_addr = 4'd2; wb_en = 1;
        tick();
        wb_en = 0; #1;
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("FAIL stall_r2_once got %0b want 0", o_hazard_stall); end
        ir_id = 16'h2000;
        tick();
        rst = 0; #1;
        m_reset();
        checks++; if (o_valid_ex !== 1'b0 || o_ir_ex !== 16'h0 || o_addr_rn_r !== 4'd0) begin errors++; $display("FAIL stall_rst got %0b/%h/%0d want 0/0000/0", o_valid_ex, o_ir_ex, o_addr_rn_r); end
        @(negedge clk);
        rst = 1; stall = 0; ir_id = 16'h1C4A;
        #1;
        checks++; if (o_hazard_stall !== 1'b0) begin errors++; $display("FAIL stall_rst_hazard got %0b want 0", o_hazard_stall); end
        tick();
        checks++; if (o_valid_ex !== 1'b1 || o_ir_ex !== 16'h1C4A) begin errors++; $display("FAIL stall_rst_issue got %0b/%h want 1/1c4a", o_valid_ex, o_ir_ex); end
        ir_valid = 0;
    endtask

    task automatic test_sb_err();
        apply_reset();
        wb_addr = 4'd7; wb_en = 1;
        tick();
        wb_en = 0;
        checks++; if (o_sb_err !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", o_sb_err); end
        repeat (3) tick();
        checks++; if (o_sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", o_sb_err); end
        rst = 0; #1;
        m_reset();
        checks++; if (o_sb_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", o_sb_err); end
        apply_reset();
    endtask

    task automatic test_random();
        int busy_regs[$];
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: ir_id = {7'b0001110, 9'($urandom)};
                1: ir_id = {9'b101100001, 7'($urandom)};
                2: ir_id = {5'b00100, 11'($urandom)};
                3: ir_id = {8'b01000110, 8'($urandom)};
                4: ir_id = {5'b01101, 11'($urandom)};
                default: ir_id = 16'($urandom);
            endcase
            ir_valid = ($urandom_range(0, 7) != 0);
            stall    = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            busy_regs.delete();
            for (int r = 0; r < 16; r++) if (m_cnt[r] != 0) busy_regs.push_back(r);
            wb_en = (busy_regs.size() != 0) && ($urandom_range(0, 1) == 1);
            wb_addr = wb_en ? 4'(busy_regs[$urandom_range(0, busy_regs.size() - 1)]) : 4'($urandom);
            #1;
            checks++; if (o_hazard_stall !== m_hazard()) begin errors++; $display("FAIL rnd_hazard n=%0d ir=%h got %0b want %0b", n, ir_id, o_hazard_stall, m_hazard()); end
            tick();
            checks++;
            if (o_valid_ex !== m_valid || o_ir_ex !== m_ir || o_addr_rn_r !== m_rn || o_addr_rm_r !== m_rm ||
                o_registers_rn_en !== m_rn_en || o_registers_rm_en !== m_rm_en || o_sb_err !== m_err) begin
                errors++;
                $display("FAIL rnd_ex n=%0d got v=%0b ir=%h rn=%0d/%0b rm=%0d/%0b err=%0b want v=%0b ir=%h rn=%0d/%0b rm=%0d/%0b err=%0b",
                         n, o_valid_ex, o_ir_ex, o_addr_rn_r, o_registers_rn_en, o_addr_rm_r, o_registers_rm_en, o_sb_err,
                         m_valid, m_ir, m_rn, m_rn_en, m_rm, m_rm_en, m_err);
            end
        end
        ir_valid = 0; stall = 0; flush = 0; wb_en = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        m_reset();
        test_reset();
        test_raw();
        test_sub_sp();
        test_same_cycle();
        test_saturate();
        test_stall_hold();
        test_sb_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
